// File: rtl/alu_issue.sv
// alu_issue: single-issue sequencer in front of an external combinational ALU.
// It holds an 8-entry register file, with r0 hard-wired to zero, and accepts
// one instruction at a time through a valid/ready handshake.
// Each instruction steps through IDLE -> EXEC -> WB.
// Optional feature: define ALU_ISSUE_FLAGS_EN to add the flag_zero/flag_neg
// outputs. These are captured from alu_out on every ALU-op writeback.
module alu_issue #(
  parameter int DATA_W = 16,
  parameter int REG_N  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [2:0]        instr_dst,
  input  logic [2:0]        instr_src_a,
  input  logic [2:0]        instr_src_b,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              wb_valid,
  output logic [2:0]        wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal_op,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              flag_zero,
  output logic              flag_neg
`endif
);

  localparam logic [3:0] OP_LOADI = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] regs [REG_N];

  // Instruction context captured at the handshake and consumed in EXEC
  logic [2:0]        dst_p0;
  logic [DATA_W-1:0] imm_p0;
  logic              loadi_p0;

  logic              is_alu;
  logic              is_loadi;
  logic              accept;
  logic [DATA_W-1:0] wr_data;

  // Opcodes 0000..0011 go to the ALU; 0100 is LOADI; everything else is illegal
  assign is_alu   = (instr_op[3:2] == 2'b00);
  assign is_loadi = (instr_op == OP_LOADI);
  assign accept   = instr_valid & instr_ready;

  // LOADI bypasses the ALU, so its immediate is what gets written back
  assign wr_data  = loadi_p0 ? imm_p0 : alu_out;

  // r0 is never written, so a plain array read already returns zero for it
  assign dbg_data = regs[dbg_sel];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake: an illegal opcode is consumed but keeps the FSM in IDLE
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid && (is_alu || is_loadi)) begin
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, register-file write at EXEC exit, and writeback report
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      dst_p0     <= '0;
      imm_p0     <= '0;
      loadi_p0   <= 1'b0;
      wb_valid   <= 1'b0;
      wb_dst     <= '0;
      wb_data    <= '0;
      illegal_op <= 1'b0;
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // Issue: capture the context; ALU operands change only for ALU ops
      illegal_op <= accept & ~is_alu & ~is_loadi;
      if (accept && is_alu) begin
        alu_a  <= regs[instr_src_a];
        alu_b  <= regs[instr_src_b];
        alu_op <= instr_op;
      end
      if (accept && (is_alu || is_loadi)) begin
        dst_p0   <= instr_dst;
        imm_p0   <= instr_imm;
        loadi_p0 <= is_loadi;
      end
      // Execute -> writeback: the report goes out even when the target is r0
      wb_valid <= (state == EXEC);
      if (state == EXEC) begin
        wb_dst  <= dst_p0;
        wb_data <= wr_data;
        if (dst_p0 != 3'd0) begin
          regs[dst_p0] <= wr_data;
        end
      end
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  // Flags follow ALU results only; LOADI writebacks leave them untouched
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_zero <= 1'b0;
      flag_neg  <= 1'b0;
    end else if (state == EXEC && !loadi_p0) begin
      flag_zero <= (alu_out == '0);
      flag_neg  <= alu_out[DATA_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue. It plays the role of the external ALU.
// The bench runs a table of instructions with hand-computed results, then
// checks reset-on-entry and an asynchronous reset landing mid-EXEC.
// Compile with ALU_ISSUE_FLAGS_EN defined to check the flag outputs as well.
module tb_alu_issue;

  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [3:0]        instr_op = '0;
  logic [2:0]        instr_dst = '0;
  logic [2:0]        instr_src_a = '0;
  logic [2:0]        instr_src_b = '0;
  logic [DATA_W-1:0] instr_imm = '0;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              wb_valid;
  logic [2:0]        wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              illegal_op;
  logic [2:0]        dbg_sel = '0;
  logic [DATA_W-1:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic              flag_zero;
  logic              flag_neg;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  alu_issue #(.DATA_W(DATA_W), .REG_N(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_dst   (instr_dst),
    .instr_src_a (instr_src_a),
    .instr_src_b (instr_src_b),
    .instr_imm   (instr_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_out     (alu_out),
    .wb_valid    (wb_valid),
    .wb_dst      (wb_dst),
    .wb_data     (wb_data),
    .illegal_op  (illegal_op),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .flag_zero   (flag_zero),
    .flag_neg    (flag_neg)
`endif
  );

  always #5 clock = ~clock;

  // External combinational ALU
  always_comb begin
    case (alu_op)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a - alu_b;
      4'd2:    alu_out = alu_a & alu_b;
      4'd3:    alu_out = alu_a | alu_b;
      default: alu_out = '0;
    endcase
  end

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  dst;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [15:0] imm;
    logic [15:0] exp_data;  // expected wb_data
    logic [15:0] exp_reg;   // expected dbg read of dst afterwards
    logic        exp_ill;
    logic        exp_z;
    logic        exp_n;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int guard;
    @(negedge clock);
    guard = 0;
    while (!instr_ready && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    chk($sformatf("v%0d ready_before", idx), {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr_op    = v.op;
    instr_dst   = v.dst;
    instr_src_a = v.sa;
    instr_src_b = v.sb;
    instr_imm   = v.imm;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    if (v.exp_ill) begin
      chk($sformatf("v%0d illegal_pulse", idx), {31'd0, illegal_op}, 32'd1);
      chk($sformatf("v%0d ill_no_wb", idx), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("v%0d ill_ready", idx), {31'd0, instr_ready}, 32'd1);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d illegal_end", idx), {31'd0, illegal_op}, 32'd0);
      chk($sformatf("v%0d ill_no_wb2", idx), {31'd0, wb_valid}, 32'd0);
    end else begin
      chk($sformatf("v%0d no_illegal", idx), {31'd0, illegal_op}, 32'd0);
      chk($sformatf("v%0d exec_wb_low", idx), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("v%0d exec_busy", idx), {31'd0, instr_ready}, 32'd0);
      @(posedge clock);
      #1;
      chk($sformatf("v%0d wb_valid", idx), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("v%0d wb_dst", idx), {29'd0, wb_dst}, {29'd0, v.dst});
      chk($sformatf("v%0d wb_data", idx), {16'd0, wb_data}, {16'd0, v.exp_data});
      @(posedge clock);
      #1;
      chk($sformatf("v%0d wb_end", idx), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("v%0d ready_after", idx), {31'd0, instr_ready}, 32'd1);
    end
    dbg_sel = v.dst;
    #1;
    chk($sformatf("v%0d dbg_dst", idx), {16'd0, dbg_data}, {16'd0, v.exp_reg});
`ifdef ALU_ISSUE_FLAGS_EN
    chk($sformatf("v%0d flag_zero", idx), {31'd0, flag_zero}, {31'd0, v.exp_z});
    chk($sformatf("v%0d flag_neg", idx), {31'd0, flag_neg}, {31'd0, v.exp_n});
`endif
  endtask

  initial begin
    //          op     dst   sa    sb    imm       wb_data   dbg       ill   z     n
    vecs[0]  = '{4'h4, 3'd1, 3'd0, 3'd0, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'h4, 3'd2, 3'd0, 3'd0, 16'h0FFF, 16'h0FFF, 16'h0FFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'h0, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h2233, 16'h2233, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'h4, 3'd1, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'h4, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'h1, 3'd4, 3'd1, 3'd2, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{4'h4, 3'd0, 3'd0, 3'd0, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'hA, 3'd4, 3'd0, 3'd0, 16'h5555, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{4'h4, 3'd5, 3'd0, 3'd0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{4'h2, 3'd6, 3'd5, 3'd3, 16'h0000, 16'h2030, 16'h2030, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'h3, 3'd7, 3'd5, 3'd2, 16'h0000, 16'hF0F1, 16'hF0F1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'h1, 3'd5, 3'd2, 3'd2, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'h0, 3'd3, 3'd4, 3'd4, 16'h0000, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{4'hF, 3'd3, 3'd0, 3'd0, 16'h1111, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{4'h0, 3'd0, 3'd3, 3'd2, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 8; s++) begin
      dbg_sel = s[2:0];
      #1;
      chk($sformatf("reset_dbg_r%0d", s), {16'd0, dbg_data}, 32'd0);
    end
    chk("reset_ready", {31'd0, instr_ready}, 32'd1);
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_wb_data", {16'd0, wb_data}, 32'd0);
    chk("reset_wb_dst", {29'd0, wb_dst}, 32'd0);
    chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
    chk("reset_alu_a", {16'd0, alu_a}, 32'd0);
    chk("reset_alu_b", {16'd0, alu_b}, 32'd0);
    chk("reset_alu_op", {28'd0, alu_op}, 32'd0);
`ifdef ALU_ISSUE_FLAGS_EN
    chk("reset_flag_zero", {31'd0, flag_zero}, 32'd0);
    chk("reset_flag_neg", {31'd0, flag_neg}, 32'd0);
`endif

    // Instruction table
    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i], i);
      if (i == 6) begin
        // LOADI must not disturb the operands left by the preceding sub r4=r1-r2
        chk("loadi_hold_alu_op", {28'd0, alu_op}, 32'd1);
        chk("loadi_hold_alu_a", {16'd0, alu_a}, 32'h0000);
        chk("loadi_hold_alu_b", {16'd0, alu_b}, 32'h0001);
      end
    end

    // Asynchronous reset while add r5=r3+r2 is in EXEC
    @(negedge clock);
    instr_valid = 1'b1;
    instr_op    = 4'h0;
    instr_dst   = 3'd5;
    instr_src_a = 3'd3;
    instr_src_b = 3'd2;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    chk("midrst_in_exec", {31'd0, instr_ready}, 32'd0);
    chk("midrst_alu_a", {16'd0, alu_a}, 32'hFFFE);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_idle_now", {31'd0, instr_ready}, 32'd1);
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst_alu_a_clr", {16'd0, alu_a}, 32'd0);
    chk("midrst_alu_op_clr", {28'd0, alu_op}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("midrst_no_wb_c%0d", c), {31'd0, wb_valid}, 32'd0);
    end
    dbg_sel = 3'd5;
    #1;
    chk("midrst_r5_zero", {16'd0, dbg_data}, 32'd0);
    dbg_sel = 3'd3;
    #1;
    chk("midrst_r3_zero", {16'd0, dbg_data}, 32'd0);

    // Operation resumes after reset
    run_vec('{4'h4, 3'd2, 3'd0, 3'd0, 16'h5A5A, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
